maxpool2x2_stream: RTL and testbench
====================================

// Module: maxpool2x2_stream
// PURPOSE
//  Streaming 2x2/stride-2 max-pooling unit with optional ReLU. Sits after the CCM partial-sum
//  output and before the output SRAM. Consumes one raster-order pixel per beat, CH channels
//  in parallel. Keeps the half-row of horizontal maxima in an internal line buffer, so no OR
//  SRAM read-back is needed. Runtime image size; valid/ready on both sides.
// PARAMETERS
//  CH      32   channels per pixel (matches CHANNEL_OUT)
//  DW      8    bits per channel value
//  MAX_W   256  max input row width; line buffer depth = MAX_W/2
//  SIGNED  1    1: channel values are two's complement; 0: unsigned
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       async active-low reset
//  start      in   1       1-cycle pulse; latches img_w/img_h/relu_en; ignored unless IDLE
//  img_w      in   9       input row width in pixels
//  img_h      in   9       input column height in rows
//  relu_en    in   1       clamp negative results to 0 (SIGNED=1 only)
//  in_valid   in   1       in_data valid
//  in_ready   out  1       unit accepts in_data this cycle
//  in_data    in   CH*DW   one pixel; channel k at [k*DW +: DW]
//  out_valid  out  1       out_data valid, held until out_ready
//  out_ready  in   1       downstream accepts out_data
//  out_data   out  CH*DW   pooled pixel, same packing as in_data
//  busy       out  1       state != IDLE
//  done       out  1       1-cycle pulse at end of frame
//  cfg_err    out  1       1-cycle pulse, coincident with done, on illegal config
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Line-buffer contents are don't-care.
//  FSM: IDLE -start-> CHECK -ok-> RUN -last input accepted-> DRAIN -out empty-> DONE -> IDLE.
//   - CHECK takes 1 cycle. It is illegal if img_w<2, img_h<2 or img_w>MAX_W.
//   - Illegal config: CHECK -> DONE, with cfg_err=1 and no output beats.
//  in_ready = (state==RUN) && (!out_valid || out_ready). A beat transfers on in_valid&&in_ready.
//  Counters col/row advance per accepted beat; col wraps at img_w-1 and row increments on wrap.
//  Pooling per channel:
//   - Even col: the pixel goes into hold reg h.
//   - Odd col, even row: lb[col>>1] <= max(h, in).
//   - Odd col, odd row: result = max(lb[col>>1], h, in), loaded into the output reg.
//  Odd img_w: last column is accepted and discarded. Odd img_h: last row is accepted and discarded.
//  Output size is floor(img_w/2) x floor(img_h/2).
//  Latency: out_valid rises the cycle after the 4th pixel of a window is accepted.
//  Backpressure: out_valid&&!out_ready stalls input, so no output beat is ever lost or
//  overwritten. Simultaneous out pop and window-complete load: the new value is loaded, and
//  out_valid stays 1.
//  Compare is signed if SIGNED=1, else unsigned. Width is preserved (DW in, DW out); no rounding.
//  ReLU is applied at output-register load: if relu_en && value[DW-1] then load 0.
//  Frame end: after the final beat (row=img_h-1, col=img_w-1) is accepted, the FSM enters DRAIN.
//  DRAIN waits until out_valid==0 or the pop happens, then goes to DONE. done pulses 1 cycle.
//  start during busy is ignored. img_* changes mid-frame have no effect; values are latched at start.
//  Reset mid-frame: immediate return to IDLE, out_valid=0, no done pulse.
// STRUCTURE
//  Shared package pool_pkg:
//   - FSM state encoding (IDLE, CHECK, RUN, DRAIN, DONE).
//   - MAXW_LOG2 helper constant.
//   - max2 function, parametrised by DW and SIGNED.
//  Sub-module maxpool_lane (one DW-bit channel): hold reg, max2 stages, relu clamp.
//  The top generates CH lanes and holds the shared counters, FSM, line buffer and handshake.
//  Line buffer: CH*DW x MAX_W/2 array, 1 write or 1 read per beat. Implemented as registers
//  or a 1R1W SRAM macro.
// TESTING
//  4x4 frame, CH=32, ch0 = raster index 0..15, no stalls:
//   - expected ch0 outputs 5, 7, 13, 15; then done pulse.
//  Signed: window {-3,-8,-1,-128}:
//   - relu_en=0 -> -1 (8'hFF).
//   - relu_en=1 -> 0.
//  5x3 frame (odd w, odd h):
//   - 15 beats accepted, 2 outputs (row 0 windows only); col 4 and row 2 discarded.
//  Backpressure: hold out_ready=0 for 10 cycles after the first output.
//   - in_ready=0 throughout; out_data stable; all outputs emitted in order after release.
//  img_w=1 start -> cfg_err and done in the same cycle 2 cycles later; no out_valid;
//   in_ready stays 0.
//  Assert rst_n mid-frame of a 256x4 frame:
//   - outputs return to 0 at once.
//   - a following 4x4 frame gives correct results, with no stale line-buffer data visible.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 max-pool stream unit.
// FSM encoding, dimension widths and the max2 compare helper.
package pool_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int MAXW_LOG2 = 8;
  localparam int DIM_W     = MAXW_LOG2 + 1;
  localparam int MAX_DW    = 32;

  // Operands are zero-extended DW-bit values. Flipping bit dw-1
  // turns a signed compare into an unsigned one.
  function automatic logic [MAX_DW-1:0] max2(
    input logic [MAX_DW-1:0] a,
    input logic [MAX_DW-1:0] b,
    input int                dw,
    input bit                sgn
  );
    logic [MAX_DW-1:0] m;
    m = sgn ? (MAX_DW'(1) << (dw - 1)) : '0;
    return ((a ^ m) >= (b ^ m)) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_lane.sv
// One channel of the pooling datapath: hold reg, max stages, ReLU.
// Ports: load strobes, pixel/line-buffer values in; pair max and output reg out.
module maxpool_lane
  import pool_pkg::*;
#(
  parameter int DW     = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          h_load,
  input  logic          o_load,
  input  logic          relu_en,
  input  logic [DW-1:0] in_val,
  input  logic [DW-1:0] lb_val,
  output logic [DW-1:0] pair_max,
  output logic [DW-1:0] out_val
);

  logic [DW-1:0]     h;
  logic [DW-1:0]     win_max;
  logic [DW-1:0]     res;
  logic [MAX_DW-1:0] pm_w;
  logic [MAX_DW-1:0] wm_w;

  assign pm_w     = max2(MAX_DW'(h), MAX_DW'(in_val), DW, SIGNED);
  assign pair_max = pm_w[DW-1:0];
  assign wm_w     = max2(MAX_DW'(lb_val), MAX_DW'(pair_max), DW, SIGNED);
  assign win_max  = wm_w[DW-1:0];
  assign res      = (relu_en && win_max[DW-1]) ? '0 : win_max;

  if (DW < MAX_DW) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^{pm_w[MAX_DW-1:DW], wm_w[MAX_DW-1:DW]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h       <= '0;
      out_val <= '0;
    end else begin
      if (h_load) h <= in_val;
      if (o_load) out_val <= res;
    end
  end

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2/stride-2 max pool with optional ReLU, CH lanes wide.
// Ports: start/img_w/img_h/relu_en cfg, in/out valid-ready streams, busy/done/cfg_err.
module maxpool2x2_stream
  import pool_pkg::*;
#(
  parameter int CH     = 32,
  parameter int DW     = 8,
  parameter int MAX_W  = 256,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [8:0]       img_w,
  input  logic [8:0]       img_h,
  input  logic             relu_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int LBD = MAX_W / 2;
  localparam int LBA = $clog2(LBD);

  state_t           state;
  logic [DIM_W-1:0] w_q;
  logic [DIM_W-1:0] h_q;
  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] row;
  logic             relu_q;
  logic             relu_act;

  logic [CH*DW-1:0] lb [LBD];
  logic [CH*DW-1:0] lb_rd;
  logic [CH*DW-1:0] pair_max;
  logic [LBA-1:0]   lb_idx;

  logic acc;
  logic col_end;
  logic last;
  logic cfg_ok;
  logic h_load;
  logic lb_we;
  logic o_load;

  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign col_end  = (col == w_q - 1'b1);
  assign last     = col_end && (row == h_q - 1'b1);
  assign cfg_ok   = (w_q >= DIM_W'(2)) && (h_q >= DIM_W'(2))
                 && (w_q <= DIM_W'(MAX_W));
  assign relu_act = relu_q & SIGNED;
  assign busy     = (state != S_IDLE);

  // Trailing odd column/row fall out naturally: an even column only
  // refreshes h, an even row only writes the line buffer.
  assign lb_idx = col[LBA:1];
  assign h_load = acc && !col[0];
  assign lb_we  = acc && col[0] && !row[0];
  assign o_load = acc && col[0] && row[0];
  assign lb_rd  = lb[lb_idx];

  for (genvar k = 0; k < CH; k++) begin : g_lane
    maxpool_lane #(
      .DW     (DW),
      .SIGNED (SIGNED)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .h_load   (h_load),
      .o_load   (o_load),
      .relu_en  (relu_act),
      .in_val   (in_data[k*DW +: DW]),
      .lb_val   (lb_rd[k*DW +: DW]),
      .pair_max (pair_max[k*DW +: DW]),
      .out_val  (out_data[k*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (lb_we) lb[lb_idx] <= pair_max;
  end

  // Input is stalled while a result waits, so a load never
  // overwrites an unpopped beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (o_load) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      col     <= '0;
      row     <= '0;
      relu_q  <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            w_q    <= img_w;
            h_q    <= img_h;
            relu_q <= relu_en;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          col <= '0;
          row <= '0;
          if (cfg_ok) begin
            state <= S_RUN;
          end else begin
            state   <= S_DONE;
            done    <= 1'b1;
            cfg_err <= 1'b1;
          end
        end
        S_RUN: begin
          if (acc) begin
            if (col_end) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!out_valid || out_ready) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream.
// Table of 2x2 windows plus directed multi-cycle frame sequences.
module tb_maxpool2x2_stream;

  localparam int CH   = 32;
  localparam int DW   = 8;
  localparam int DWID = CH * DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [8:0]      img_w = '0;
  logic [8:0]      img_h = '0;
  logic            relu_en = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DWID-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DWID-1:0] out_data;
  logic            busy;
  logic            done;
  logic            cfg_err;

  maxpool2x2_stream #(
    .CH(CH), .DW(DW), .MAX_W(256), .SIGNED(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .img_w     (img_w),
    .img_h     (img_h),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int cfg_cnt = 0;
  int bad_err = 0;

  logic [DWID-1:0] outq[$];
  logic [DWID-1:0] pq[$];

  always @(negedge clk) begin
    if (out_valid && out_ready) outq.push_back(out_data);
    if (done) done_cnt++;
    if (cfg_err) cfg_cnt++;
    if (cfg_err && !done) bad_err++;
  end

  typedef struct packed {
    logic [7:0] p0;
    logic [7:0] p1;
    logic [7:0] p2;
    logic [7:0] p3;
    logic       relu;
    logic [7:0] exp;
  } vec_t;

  vec_t tv[8];

  task automatic checkd(input string nm, input logic [DWID-1:0] act,
                        input logic [DWID-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic checkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [DWID-1:0] rep(input logic [7:0] b);
    return {CH{b}};
  endfunction

  function automatic logic [DWID-1:0] px01(input int idx);
    logic [DWID-1:0] d;
    d = '0;
    d[7:0]  = 8'(idx);
    d[15:8] = 8'(15 - idx);
    return d;
  endfunction

  function automatic logic [DWID-1:0] mk(input int e0, input int e1);
    logic [DWID-1:0] d;
    d = '0;
    d[7:0]  = 8'(e0);
    d[15:8] = 8'(e1);
    return d;
  endfunction

  task automatic start_frame(input int w, input int h, input logic relu);
    @(posedge clk); #1;
    img_w   = 9'(w);
    img_h   = 9'(h);
    relu_en = relu;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_q(input int limit, output int beats);
    int guard;
    guard = 0;
    beats = 0;
    while (pq.size() > 0 && beats < limit && guard < 5000) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = pq[0];
      @(negedge clk);
      guard++;
      if (in_ready) begin
        void'(pq.pop_front());
        beats++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (guard >= 5000) begin
      n_chk++;
      n_fail++;
      $display("FAIL drive_timeout: got %0d beats expected %0d", beats, limit);
    end
  endtask

  task automatic wait_done(input int base, input string nm);
    int g;
    g = 0;
    while (done_cnt == base && g < 2000) begin
      @(negedge clk);
      g++;
    end
    checki(nm, done_cnt, base + 1);
  endtask

  initial begin
    int base;
    int beats;
    int e0[4];
    int e1[4];
    logic [DWID-1:0] snap;
    int bp_rdy;
    int bp_chg;
    int bp_seen;

    tv[0] = '{8'hFD, 8'hF8, 8'hFF, 8'h80, 1'b0, 8'hFF};
    tv[1] = '{8'hFD, 8'hF8, 8'hFF, 8'h80, 1'b1, 8'h00};
    tv[2] = '{8'h0A, 8'h14, 8'h1E, 8'h28, 1'b0, 8'h28};
    tv[3] = '{8'h7F, 8'h80, 8'h00, 8'h05, 1'b1, 8'h7F};
    tv[4] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 8'h80};
    tv[5] = '{8'hFB, 8'hFE, 8'hF9, 8'hF7, 1'b1, 8'h00};
    tv[6] = '{8'h01, 8'h01, 8'h01, 8'h01, 1'b1, 8'h01};
    tv[7] = '{8'h05, 8'h7E, 8'h81, 8'h7D, 1'b0, 8'h7E};
    e0 = '{5, 7, 13, 15};
    e1 = '{15, 13, 7, 5};

    // reset state
    #12;
    checkb("rst_out_valid", out_valid, 1'b0);
    checkb("rst_in_ready", in_ready, 1'b0);
    checkb("rst_busy", busy, 1'b0);
    checkb("rst_done", done, 1'b0);
    checkb("rst_cfg_err", cfg_err, 1'b0);
    checkd("rst_out_data", out_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 4x4 frame, no stalls
    outq.delete();
    base = done_cnt;
    start_frame(4, 4, 1'b0);
    for (int i = 0; i < 16; i++) pq.push_back(px01(i));
    drive_q(16, beats);
    wait_done(base, "f4x4_done");
    checki("f4x4_beats", beats, 16);
    checki("f4x4_count", outq.size(), 4);
    for (int i = 0; i < 4 && i < outq.size(); i++)
      checkd($sformatf("f4x4_out%0d", i), outq[i], mk(e0[i], e1[i]));

    // table of single 2x2 windows
    for (int t = 0; t < 8; t++) begin
      outq.delete();
      base = done_cnt;
      start_frame(2, 2, tv[t].relu);
      pq.push_back(rep(tv[t].p0));
      pq.push_back(rep(tv[t].p1));
      pq.push_back(rep(tv[t].p2));
      pq.push_back(rep(tv[t].p3));
      drive_q(4, beats);
      wait_done(base, $sformatf("tv%0d_done", t));
      checki($sformatf("tv%0d_count", t), outq.size(), 1);
      if (outq.size() > 0)
        checkd($sformatf("tv%0d_data", t), outq[0], rep(tv[t].exp));
    end

    // 5x3 frame: last column and last row discarded
    outq.delete();
    base = done_cnt;
    start_frame(5, 3, 1'b0);
    for (int i = 0; i < 15; i++) pq.push_back(px01(i));
    drive_q(15, beats);
    wait_done(base, "f5x3_done");
    checki("f5x3_beats", beats, 15);
    checki("f5x3_count", outq.size(), 2);
    if (outq.size() >= 2) begin
      checkd("f5x3_out0", outq[0], mk(6, 15));
      checkd("f5x3_out1", outq[1], mk(8, 13));
    end

    // backpressure after the first output
    outq.delete();
    out_ready = 1'b0;
    base = done_cnt;
    bp_rdy = 0;
    bp_chg = 0;
    bp_seen = 0;
    snap = '0;
    start_frame(4, 4, 1'b0);
    for (int i = 0; i < 16; i++) pq.push_back(px01(i));
    fork
      drive_q(16, beats);
      begin
        for (int g = 0; g < 200 && bp_seen == 0; g++) begin
          @(negedge clk);
          if (out_valid) begin
            bp_seen = 1;
            snap = out_data;
          end
        end
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (in_ready) bp_rdy++;
          if (out_data !== snap) bp_chg++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_done(base, "bp_done");
    checki("bp_first_seen", bp_seen, 1);
    checkd("bp_first_data", snap, mk(5, 15));
    checki("bp_in_ready_cycles", bp_rdy, 0);
    checki("bp_data_changes", bp_chg, 0);
    checki("bp_count", outq.size(), 4);
    for (int i = 0; i < 4 && i < outq.size(); i++)
      checkd($sformatf("bp_out%0d", i), outq[i], mk(e0[i], e1[i]));

    // illegal width 1: cfg_err with done two cycles after start
    outq.delete();
    base = done_cnt;
    start_frame(1, 4, 1'b0);
    @(negedge clk);
    checkb("cfg1_done_early", done, 1'b0);
    @(negedge clk);
    checkb("cfg1_done", done, 1'b1);
    checkb("cfg1_err", cfg_err, 1'b1);
    checkb("cfg1_out_valid", out_valid, 1'b0);
    checkb("cfg1_in_ready", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    checkb("cfg1_idle", busy, 1'b0);

    // illegal width above MAX_W
    base = done_cnt;
    start_frame(257, 4, 1'b0);
    wait_done(base, "cfg257_done");
    checki("cfg_err_pulses", cfg_cnt, 2);
    checki("cfg_no_output", outq.size(), 0);

    // reset in the middle of a 256x4 frame
    outq.delete();
    start_frame(256, 4, 1'b0);
    for (int i = 0; i < 1024; i++) pq.push_back(rep(8'h7F));
    drive_q(300, beats);
    out_ready = 1'b0;
    @(negedge clk);
    checkb("mid_pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    checkb("mid_rst_valid", out_valid, 1'b0);
    checkb("mid_rst_busy", busy, 1'b0);
    checkb("mid_rst_in_ready", in_ready, 1'b0);
    checkd("mid_rst_data", out_data, '0);
    base = done_cnt;
    pq.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checki("mid_no_done", done_cnt, base);

    // fresh 4x4 after reset: no stale line-buffer data
    outq.delete();
    start_frame(4, 4, 1'b0);
    for (int i = 0; i < 16; i++) pq.push_back(px01(i));
    drive_q(16, beats);
    wait_done(base, "post_done");
    checki("post_count", outq.size(), 4);
    for (int i = 0; i < 4 && i < outq.size(); i++)
      checkd($sformatf("post_out%0d", i), outq[i], mk(e0[i], e1[i]));

    checki("cfg_err_without_done", bad_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
